dmem_mmio_responder: RTL and testbench

//  - Responder side of the pipelined core's data-memory port (MemWrite / ALUResult_M / WriteData_M / ReadData).
//  - Decodes each M-stage access to one of two targets: word RAM, or a small MMIO page.
//  - MMIO page holds a free-running cycle counter, an LED register, a TX byte FIFO and a status register.
//  - TX FIFO drains over a valid/ready handshake to a downstream sink (UART/monitor).

---
 rtl/dmem_mmio_responder_pkg.sv | 33 +++
 rtl/dmem_mmio_responder_if.sv | 20 ++
 rtl/dmem_mmio_responder_tx_fifo.sv | 69 ++++++
 rtl/dmem_mmio_responder.sv | 124 ++++++++++++
 tb/tb_dmem_mmio_responder.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_mmio_responder_pkg.sv
// Address map, decode targets and STATUS register layout shared by the data-memory responder.
package dmem_mmio_responder_pkg;

    typedef enum logic [1:0] {
        TGT_RAM,
        TGT_MMIO,
        TGT_NONE
    } target_e;

    localparam logic [3:0] OFF_CYCLE  = 4'h0;
    localparam logic [3:0] OFF_LED    = 4'h4;
    localparam logic [3:0] OFF_TXDATA = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int unsigned STATUS_EMPTY_BIT = 0;
    localparam int unsigned STATUS_FULL_BIT  = 1;
    localparam int unsigned STATUS_OVF_BIT   = 2;
    localparam int unsigned STATUS_COUNT_LSB = 16;

    // RAM is checked first so a base overlapping the RAM range still lands in RAM.
    function automatic target_e decode_target(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes,
                                              input logic [31:0] mmio_base);
        if (addr < ram_bytes) begin
            return TGT_RAM;
        end
        if ((addr & 32'hFFFF_FFF0) == (mmio_base & 32'hFFFF_FFF0)) begin
            return TGT_MMIO;
        end
        return TGT_NONE;
    endfunction

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// Core data-memory port plus the TX byte stream toward the downstream sink.
interface dmem_mmio_responder_if;
    logic        MemWrite;
    logic [31:0] ALUResult_M;
    logic [31:0] WriteData_M;
    logic [31:0] ReadData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output MemWrite, ALUResult_M, WriteData_M, tx_ready,
        input  ReadData, tx_data, tx_valid
    );

    modport slave (
        input  MemWrite, ALUResult_M, WriteData_M, tx_ready,
        output ReadData, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_mmio_responder_tx_fifo.sv
// Circular TX byte FIFO; a push into a full FIFO is accepted only when a pop frees a slot.
module dmem_mmio_responder_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    output logic                     push_ok_o,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int unsigned Aw = $clog2(DEPTH);
    localparam logic [Aw:0] FullCount = (Aw + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [Aw-1:0]    wr_ptr_q, wr_ptr_d;
    logic [Aw-1:0]    rd_ptr_q, rd_ptr_d;
    logic [Aw:0]      count_q, count_d;
    logic             pop_eff;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == FullCount);
    assign pop_eff   = pop_i && !empty_o;
    assign push_ok_o = push_i && (!full_o || pop_eff);
    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_o) begin
            wr_ptr_d = wr_ptr_q + Aw'(1);
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + Aw'(1);
        end
        if (push_ok_o && !pop_eff) begin
            count_d = count_q + (Aw + 1)'(1);
        end else if (!push_ok_o && pop_eff) begin
            count_d = count_q - (Aw + 1)'(1);
        end
    end

    // Storage is cleared so tx_data reads 0 out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_o) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM plus an MMIO page with cycle counter, LED, TX FIFO and status.
module dmem_mmio_responder
    import dmem_mmio_responder_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_mmio_responder_if.slave bus,
    output logic [7:0]           led
);
    localparam int unsigned RamAw    = $clog2(RAM_WORDS);
    localparam int unsigned CntW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RamBytes = 32'(RAM_WORDS * 4);

    target_e          tgt;
    logic [3:0]       offset;
    logic [RamAw-1:0] ram_idx;
    logic             ram_we;
    logic             mmio_we;
    logic [31:0]      ram_q [RAM_WORDS];
    logic [31:0]      cycle_q, cycle_d;
    logic [7:0]       led_q, led_d;
    logic             ovf_q, ovf_d;
    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CntW-1:0]  fifo_count;
    logic [7:0]       fifo_head;
    logic [31:0]      status;

    always_comb begin
        tgt = decode_target(bus.ALUResult_M, RamBytes, MMIO_BASE);
    end

    assign offset       = {bus.ALUResult_M[3:2], 2'b00};
    assign ram_idx      = bus.ALUResult_M[RamAw+1:2];
    assign ram_we       = bus.MemWrite && (tgt == TGT_RAM);
    assign mmio_we      = bus.MemWrite && (tgt == TGT_MMIO);
    assign push_req     = mmio_we && (offset == OFF_TXDATA);
    assign pop          = !fifo_empty && bus.tx_ready;
    assign bus.tx_valid = !fifo_empty;
    assign bus.tx_data  = fifo_head;
    assign led          = led_q;
    assign status       = {16'(fifo_count), 13'b0, ovf_q, fifo_full, fifo_empty};

    dmem_mmio_responder_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (push_req),
        .push_data_i (bus.WriteData_M[7:0]),
        .push_ok_o   (push_ok),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // Combinational read of the array gives the old word on a same-cycle write.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= bus.WriteData_M;
        end
    end

    always_comb begin
        bus.ReadData = '0;
        unique case (tgt)
            TGT_RAM:  bus.ReadData = ram_q[ram_idx];
            TGT_MMIO: begin
                case (offset)
                    OFF_CYCLE:  bus.ReadData = cycle_q;
                    OFF_LED:    bus.ReadData = {24'b0, led_q};
                    OFF_STATUS: bus.ReadData = status;
                    default:    bus.ReadData = '0;
                endcase
            end
            default:  bus.ReadData = '0;
        endcase
    end

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        led_d   = led_q;
        ovf_d   = ovf_q;
        if (mmio_we) begin
            case (offset)
                OFF_CYCLE:  cycle_d = bus.WriteData_M;
                OFF_LED:    led_d = bus.WriteData_M[7:0];
                OFF_STATUS: begin
                    if (bus.WriteData_M[STATUS_OVF_BIT]) begin
                        ovf_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        // Set has priority over a same-cycle clear.
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q <= '0;
            led_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            led_q   <= led_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Randomised self-checking bench for dmem_mmio_responder against a queue/array reference model.
module tb_dmem_mmio_responder;
    localparam logic [31:0] MmioBase = 32'h1000_0000;
    localparam logic [31:0] RamBytes = 32'd256;
    localparam int          RamWords = 64;
    localparam int          Depth    = 8;

    logic       clk;
    logic       reset;
    logic [7:0] led;

    dmem_mmio_responder_if bus();

    dmem_mmio_responder #(
        .RAM_WORDS  (64),
        .FIFO_DEPTH (8),
        .MMIO_BASE  (32'h1000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .led   (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    logic [31:0] m_ram [int];
    logic [7:0]  mq[$];
    logic [7:0]  acc_q[$];
    logic [7:0]  sink_obs[$];
    logic [31:0] m_cyc;
    logic [7:0]  m_led;
    bit          m_ovf;

    function automatic logic [31:0] status_exp();
        logic [15:0] c;
        c = 16'(mq.size());
        return {c, 13'b0, m_ovf, (mq.size() == Depth), (mq.size() == 0)};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_cyc = 32'd0;
        m_led = 8'd0;
        m_ovf = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd);
        bus.MemWrite    = we;
        bus.ALUResult_M = a;
        bus.WriteData_M = wd;
        #1;
    endtask

    // Applies the current inputs to the model, then advances one clock.
    task automatic tick();
        logic [31:0] a;
        logic [31:0] wd;
        bit          m_pop;
        bit          ok;
        a     = bus.ALUResult_M;
        wd    = bus.WriteData_M;
        m_pop = (mq.size() != 0) && bus.tx_ready;
        if (bus.tx_valid && bus.tx_ready) sink_obs.push_back(bus.tx_data);
        m_cyc = m_cyc + 32'd1;
        if (bus.MemWrite) begin
            if (a < RamBytes) begin
                m_ram[int'(a[31:2]) % RamWords] = wd;
            end else if ((a & 32'hFFFF_FFF0) == MmioBase) begin
                case (a[3:2])
                    2'd0: m_cyc = wd;
                    2'd1: m_led = wd[7:0];
                    2'd2: begin
                        ok = (mq.size() < Depth) || m_pop;
                        if (ok) begin
                            mq.push_back(wd[7:0]);
                            acc_q.push_back(wd[7:0]);
                        end else begin
                            m_ovf = 1'b1;
                        end
                    end
                    default: if (wd[2]) m_ovf = 1'b0;
                endcase
            end
        end
        if (m_pop) void'(mq.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.tx_ready = 1'b0;
        drive(1'b0, MmioBase + 32'hC, 32'd0);
        #2;
        n_checks++; if (led !== 8'd0) begin n_fail++;
            $display("FAIL reset_led: got %h want 00", led); end
        n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); end
        n_checks++; if (bus.tx_data !== 8'd0) begin n_fail++;
            $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
        n_checks++; if (bus.ReadData !== 32'h0000_0001) begin n_fail++;
            $display("FAIL reset_status: got %h want 00000001", bus.ReadData); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        drive(1'b0, MmioBase, 32'd0);
        n_checks++; if (bus.ReadData !== 32'd0) begin n_fail++;
            $display("FAIL reset_cycle: got %h want 0", bus.ReadData); end
    endtask

    task automatic test_ram();
        logic [31:0] a;
        logic [31:0] w;
        drive(1'b1, 32'h10, 32'h1111_2222); tick();
        drive(1'b1, 32'h10, 32'h3333_4444);
        n_checks++; if (bus.ReadData !== 32'h1111_2222) begin n_fail++;
            $display("FAIL ram_rdw_old: got %h want 11112222", bus.ReadData); end
        tick();
        drive(1'b0, 32'h10, 32'd0);
        n_checks++; if (bus.ReadData !== 32'h3333_4444) begin n_fail++;
            $display("FAIL ram_rdw_new: got %h want 33334444", bus.ReadData); end
        drive(1'b1, 32'h8, 32'hDEAD_BEEF); tick();
        drive(1'b0, 32'h8, 32'd0);
        n_checks++; if (bus.ReadData !== 32'hDEAD_BEEF) begin n_fail++;
            $display("FAIL ram_deadbeef: got %h want deadbeef", bus.ReadData); end
        drive(1'b0, 32'hB, 32'd0);
        n_checks++; if (bus.ReadData !== 32'hDEAD_BEEF) begin n_fail++;
            $display("FAIL ram_lowbits: got %h want deadbeef", bus.ReadData); end
        drive(1'b0, 32'h400, 32'd0);
        n_checks++; if (bus.ReadData !== 32'd0) begin n_fail++;
            $display("FAIL unmapped_rd: got %h want 0", bus.ReadData); end
        drive(1'b1, 32'h0, 32'h0BAD_0000); tick();
        drive(1'b1, 32'h400, 32'hFFFF_FFFF); tick();
        drive(1'b0, 32'h0, 32'd0);
        n_checks++; if (bus.ReadData !== 32'h0BAD_0000) begin n_fail++;
            $display("FAIL unmapped_wr_alias: got %h want 0bad0000", bus.ReadData); end
        for (int i = 0; i < 24; i++) begin
            a = {24'd0, 6'($urandom_range(0, RamWords - 1)), 2'($urandom_range(0, 3))};
            w = $urandom;
            drive(1'b1, a, w); tick();
        end
        foreach (m_ram[k]) begin
            drive(1'b0, 32'(k) << 2, 32'd0);
            n_checks++; if (bus.ReadData !== m_ram[k]) begin n_fail++;
                $display("FAIL ram_rand[%0d]: got %h want %h", k, bus.ReadData, m_ram[k]); end
        end
    endtask

    task automatic test_led();
        drive(1'b1, MmioBase + 32'h4, 32'h0000_00A5); tick();
        n_checks++; if (led !== 8'hA5 || led !== m_led) begin n_fail++;
            $display("FAIL led_write: got %h want a5", led); end
        drive(1'b1, MmioBase + 32'h4, 32'h1234_56C3);
        n_checks++; if (bus.ReadData !== 32'h0000_00A5) begin n_fail++;
            $display("FAIL led_read: got %h want 000000a5", bus.ReadData); end
        tick();
        n_checks++; if (led !== 8'hC3) begin n_fail++;
            $display("FAIL led_low_byte: got %h want c3", led); end
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, MmioBase + 32'h8, 32'(8'h30 + i)); tick();
        end
        drive(1'b0, MmioBase, 32'd0);
        n_checks++; if (bus.tx_valid !== 1'b1) begin n_fail++;
            $display("FAIL pre_reset_valid: got %b want 1", bus.tx_valid); end
        bus.tx_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (led !== 8'd0) begin n_fail++;
            $display("FAIL async_reset_led: got %h want 00", led); end
        n_checks++; if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'd0) begin n_fail++;
            $display("FAIL async_reset_fifo: got valid %b data %h want 0 00",
                     bus.tx_valid, bus.tx_data); end
        n_checks++; if (bus.ReadData !== 32'd0) begin n_fail++;
            $display("FAIL async_reset_cycle: got %h want 0", bus.ReadData); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.tx_ready = 1'b0;
        model_reset();
    endtask

    task automatic test_cycle();
        drive(1'b1, MmioBase, 32'd100); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, MmioBase, 32'd0);
            n_checks++; if (bus.ReadData !== 32'(100 + i) || bus.ReadData !== m_cyc) begin
                n_fail++;
                $display("FAIL cycle_count[%0d]: got %0d want %0d", i, bus.ReadData, 100 + i);
            end
            tick();
        end
        drive(1'b1, MmioBase, 32'hFFFF_FFFF); tick();
        drive(1'b0, MmioBase, 32'd0);
        n_checks++; if (bus.ReadData !== 32'hFFFF_FFFF) begin n_fail++;
            $display("FAIL cycle_max: got %h want ffffffff", bus.ReadData); end
        tick();
        n_checks++; if (bus.ReadData !== 32'd0 || bus.ReadData !== m_cyc) begin n_fail++;
            $display("FAIL cycle_wrap: got %h want 00000000", bus.ReadData); end
    endtask

    task automatic test_overflow();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, MmioBase + 32'h8, 32'(8'h41 + i)); tick();
        end
        drive(1'b0, MmioBase + 32'hC, 32'd0);
        n_checks++; if (bus.ReadData !== 32'h0008_0002 || bus.ReadData !== status_exp()) begin
            n_fail++; $display("FAIL status_full: got %h want 00080002", bus.ReadData); end
        drive(1'b0, MmioBase + 32'h8, 32'd0);
        n_checks++; if (bus.ReadData !== 32'd0) begin n_fail++;
            $display("FAIL txdata_read: got %h want 0", bus.ReadData); end
        drive(1'b1, MmioBase + 32'h8, 32'h0000_0049); tick();
        drive(1'b0, MmioBase + 32'hC, 32'd0);
        n_checks++; if (bus.ReadData !== 32'h0008_0006 || bus.ReadData !== status_exp()) begin
            n_fail++; $display("FAIL status_ovf: got %h want 00080006", bus.ReadData); end
        drive(1'b1, MmioBase + 32'hC, 32'h0000_0004); tick();
        drive(1'b0, MmioBase + 32'hC, 32'd0);
        n_checks++; if (bus.ReadData !== 32'h0008_0002) begin n_fail++;
            $display("FAIL status_w1c: got %h want 00080002", bus.ReadData); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_seq[$];
        sink_obs.delete();
        bus.tx_ready = 1'b1;
        drive(1'b1, MmioBase + 32'h8, 32'h0000_0055);
        n_checks++; if (bus.tx_data !== 8'h41) begin n_fail++;
            $display("FAIL full_head: got %h want 41", bus.tx_data); end
        tick();
        drive(1'b0, MmioBase + 32'hC, 32'd0);
        n_checks++; if (bus.ReadData !== 32'h0008_0002) begin n_fail++;
            $display("FAIL full_push_pop_status: got %h want 00080002", bus.ReadData); end
        for (int i = 0; i < 20 && bus.tx_valid; i++) tick();
        for (int i = 0; i < 8; i++) exp_seq.push_back(8'(8'h41 + i));
        exp_seq.push_back(8'h55);
        n_checks++; if (sink_obs.size() != exp_seq.size()) begin n_fail++;
            $display("FAIL drain_len: got %0d want %0d", sink_obs.size(), exp_seq.size()); end
        for (int i = 0; i < exp_seq.size() && i < sink_obs.size(); i++) begin
            n_checks++; if (sink_obs[i] !== exp_seq[i]) begin n_fail++;
                $display("FAIL drain_seq[%0d]: got %h want %h", i, sink_obs[i], exp_seq[i]); end
        end
    endtask

    task automatic test_random_stream();
        bit         hold;
        logic [7:0] prev;
        bit         is_push;
        sink_obs.delete();
        acc_q.delete();
        hold = 1'b0;
        prev = 8'd0;
        for (int c = 0; c < 200; c++) begin
            bus.tx_ready = 1'($urandom_range(0, 1));
            is_push = (c % 3 == 0);
            if (is_push) drive(1'b1, MmioBase + 32'h8, 32'($urandom_range(0, 255)));
            else drive(1'b0, MmioBase + 32'hC, 32'd0);
            n_checks++; if (bus.tx_valid !== (mq.size() != 0)) begin n_fail++;
                $display("FAIL rand_valid[%0d]: got %b want %b", c, bus.tx_valid, mq.size() != 0);
            end
            if (mq.size() != 0) begin
                n_checks++; if (bus.tx_data !== mq[0]) begin n_fail++;
                    $display("FAIL rand_head[%0d]: got %h want %h", c, bus.tx_data, mq[0]); end
            end
            if (hold) begin
                n_checks++; if (bus.tx_data !== prev) begin n_fail++;
                    $display("FAIL rand_stable[%0d]: got %h want %h", c, bus.tx_data, prev); end
            end
            if (!is_push) begin
                n_checks++; if (bus.ReadData !== status_exp() || bus.ReadData[31:16] > 16'd8)
                begin n_fail++;
                    $display("FAIL rand_status[%0d]: got %h want %h", c, bus.ReadData,
                             status_exp()); end
            end
            hold = bus.tx_valid && !bus.tx_ready;
            prev = bus.tx_data;
            tick();
        end
        bus.tx_ready = 1'b1;
        drive(1'b0, MmioBase + 32'hC, 32'd0);
        for (int i = 0; i < 40 && bus.tx_valid; i++) tick();
        n_checks++; if (bus.tx_valid !== 1'b0 || sink_obs.size() != acc_q.size()) begin
            n_fail++; $display("FAIL rand_drain: got %0d bytes want %0d", sink_obs.size(),
                               acc_q.size()); end
        for (int i = 0; i < acc_q.size() && i < sink_obs.size(); i++) begin
            n_checks++; if (sink_obs[i] !== acc_q[i]) begin n_fail++;
                $display("FAIL rand_order[%0d]: got %h want %h", i, sink_obs[i], acc_q[i]); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.MemWrite    = 1'b0;
        bus.ALUResult_M = 32'd0;
        bus.WriteData_M = 32'd0;
        bus.tx_ready    = 1'b0;
        reset           = 1'b0;
        model_reset();
        test_reset();
        test_ram();
        test_led();
        test_cycle();
        test_overflow();
        test_full_push_pop();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
